// File: rtl/interboard_link.sv
// interboard_link: half-duplex 4-phase handshake message link with TX queue, synchronisers, timeouts and resync
// Ports:
//   clk, rst (async, active-low)
//   transmit           1: drive Request/data and sample Ack; 0: drive Ack and sample Request/data
//   tx_valid/tx_msg    enqueue a message; tx_ready = queue can accept this cycle
//   tx_busy            TX FSM active or queue non-empty
//   tx_err             pulse: TX frame aborted (timeout or transmit dropped mid-frame)
//   rx_valid/rx_msg    pulse with a newly completed message; rx_msg holds the last one
//   rx_err             pulse: partial RX frame discarded
//   Request, Ack, interboard_data   shared tri-state board pins
module interboard_link #(
    parameter int DATA_W  = 6,
    parameter int MSG_W   = 22,
    parameter int DEPTH   = 4,
    parameter int SETUP   = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              transmit,
    input  logic              tx_valid,
    input  logic [MSG_W-1:0]  tx_msg,
    output logic              tx_ready,
    output logic              tx_busy,
    output logic              tx_err,
    output logic              rx_valid,
    output logic [MSG_W-1:0]  rx_msg,
    output logic              rx_err,
    inout  wire               Request,
    inout  wire               Ack,
    inout  wire  [DATA_W-1:0] interboard_data
);
    localparam int NW = (MSG_W + DATA_W - 1) / DATA_W;
    localparam int BW = NW * DATA_W;
    localparam int AW = $clog2(DEPTH);
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;
    localparam int CW = $clog2(2 * TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(2 * TIMEOUT);

    typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_DRIVE, TX_REQ_HI, TX_REQ_LO, TX_GAP} tx_state_t;
    typedef enum logic {RX_WAIT_HI, RX_WAIT_LO} rx_state_t;

    logic req_meta_q, req_s_q, ack_meta_q, ack_s_q;

    logic [MSG_W-1:0] mem_q [DEPTH];
    logic [MSG_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push, pop;

    tx_state_t        tx_state_q, tx_state_d;
    logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
    logic [WW-1:0]    tx_word_q, tx_word_d;
    logic [BW-1:0]    tx_buf_q, tx_buf_d;
    logic             tx_err_q, tx_abort;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
    logic [WW-1:0]    rx_word_q, rx_word_d;
    logic [BW-1:0]    rx_buf_q, rx_buf_d;
    logic [MSG_W-1:0] rx_msg_q, rx_msg_d;
    logic             rx_valid_q, rx_err_q, rx_done, rx_abort, rx_mid;

    // Pins change direction with transmit even while in reset
    assign Request         = transmit ? (tx_state_q == TX_REQ_HI) : 1'bz;
    assign Ack             = transmit ? 1'bz : (rx_state_q == RX_WAIT_LO);
    assign interboard_data = transmit ? tx_buf_q[int'(tx_word_q) * DATA_W +: DATA_W] : {DATA_W{1'bz}};

    assign tx_busy  = (tx_state_q != TX_IDLE) || (count_q != '0);
    assign tx_err   = tx_err_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;
    assign rx_msg   = rx_msg_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            req_meta_q <= Request;
            req_s_q    <= req_meta_q;
            ack_meta_q <= Ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    // A pop in LOAD frees a slot, so a full queue can still accept in that cycle
    always_comb begin
        pop      = tx_state_q == TX_LOAD;
        tx_ready = (count_q != (AW+1)'(DEPTH)) || pop;
        push     = tx_valid && tx_ready;
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = tx_msg;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_word_d  = tx_word_q;
        tx_buf_d   = tx_buf_q;
        tx_abort   = 1'b0;
        case (tx_state_q)
            TX_IDLE:   if (transmit && count_q != '0) tx_state_d = TX_LOAD;
            TX_LOAD: begin
                tx_buf_d   = BW'(mem_q[rd_ptr_q]);
                tx_word_d  = '0;
                tx_state_d = TX_DRIVE;
            end
            TX_DRIVE:  if (int'(tx_cnt_q) + 1 >= SETUP) tx_state_d = TX_REQ_HI;
            TX_REQ_HI: begin
                if (ack_s_q) tx_state_d = TX_REQ_LO;
                else tx_abort = int'(tx_cnt_q) + 1 >= TIMEOUT;
            end
            TX_REQ_LO: begin
                if (!ack_s_q) begin
                    tx_state_d = (tx_word_q == WW'(NW - 1)) ? TX_IDLE : TX_DRIVE;
                    tx_word_d  = tx_word_q + 1'b1;
                end else begin
                    tx_abort = int'(tx_cnt_q) + 1 >= TIMEOUT;
                end
            end
            TX_GAP:    if (int'(tx_cnt_q) + 1 >= 2 * TIMEOUT) tx_state_d = TX_IDLE;
            default:   tx_state_d = TX_IDLE;
        endcase
        if (!transmit && tx_state_q inside {TX_LOAD, TX_DRIVE, TX_REQ_HI, TX_REQ_LO}) tx_abort = 1'b1;
        // GAP holds Request low long enough for the far RX to time out and resync
        if (tx_abort) tx_state_d = TX_GAP;
        tx_cnt_d = (tx_state_d != tx_state_q) ? '0 : (tx_cnt_q == CNT_MAX) ? tx_cnt_q : tx_cnt_q + 1'b1;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_word_d  = rx_word_q;
        rx_buf_d   = rx_buf_q;
        rx_done    = 1'b0;
        rx_abort   = 1'b0;
        rx_mid     = (rx_word_q != '0) || (rx_state_q == RX_WAIT_LO);
        if (transmit) begin
            rx_abort = rx_mid;
        end else if (rx_state_q == RX_WAIT_HI) begin
            if (req_s_q) begin
                rx_buf_d[int'(rx_word_q) * DATA_W +: DATA_W] = interboard_data;
                rx_state_d = RX_WAIT_LO;
            end else begin
                rx_abort = rx_mid && (int'(rx_cnt_q) + 1 >= TIMEOUT);
            end
        end else begin
            if (!req_s_q) begin
                rx_state_d = RX_WAIT_HI;
                rx_done    = rx_word_q == WW'(NW - 1);
                rx_word_d  = rx_done ? '0 : rx_word_q + 1'b1;
            end else begin
                rx_abort = int'(rx_cnt_q) + 1 >= TIMEOUT;
            end
        end
        if (rx_abort) begin
            rx_state_d = RX_WAIT_HI;
            rx_word_d  = '0;
        end
        rx_msg_d = rx_done ? rx_buf_q[MSG_W-1:0] : rx_msg_q;
        rx_cnt_d = (rx_state_d != rx_state_q) ? '0 : (rx_cnt_q == CNT_MAX) ? rx_cnt_q : rx_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_word_q  <= '0;
            tx_buf_q   <= '0;
            tx_err_q   <= 1'b0;
            rx_state_q <= RX_WAIT_HI;
            rx_cnt_q   <= '0;
            rx_word_q  <= '0;
            rx_buf_q   <= '0;
            rx_msg_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_word_q  <= tx_word_d;
            tx_buf_q   <= tx_buf_d;
            tx_err_q   <= tx_abort;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_word_q  <= rx_word_d;
            rx_buf_q   <= rx_buf_d;
            rx_msg_q   <= rx_msg_d;
            rx_valid_q <= rx_done;
            rx_err_q   <= rx_abort;
        end
    end
endmodule

// File: tb/tb_interboard_link.sv
// tb_interboard_link: randomized bench acting as the far board, checked against a queue-based model
module tb_interboard_link;
    localparam int DATA_W = 6;
    localparam int MSG_W  = 22;
    localparam int DEPTH  = 4;
    localparam int SETUP  = 1;
    localparam int T      = 255;
    localparam int NW     = (MSG_W + DATA_W - 1) / DATA_W;

    logic clk = 1'b0, rst = 1'b0, transmit = 1'b0, tx_valid = 1'b0;
    logic [MSG_W-1:0] tx_msg = '0;
    wire tx_ready, tx_busy, tx_err, rx_valid, rx_err;
    wire [MSG_W-1:0] rx_msg;
    wire Request, Ack;
    wire [DATA_W-1:0] interboard_data;
    logic tb_req = 1'b0, tb_ack = 1'b0;
    logic [DATA_W-1:0] tb_data = '0;

    assign Request         = transmit ? 1'bz : tb_req;
    assign Ack             = transmit ? tb_ack : 1'bz;
    assign interboard_data = transmit ? {DATA_W{1'bz}} : tb_data;

    interboard_link #(.DATA_W(DATA_W), .MSG_W(MSG_W), .DEPTH(DEPTH), .SETUP(SETUP), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .transmit(transmit), .tx_valid(tx_valid), .tx_msg(tx_msg),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_err(tx_err), .rx_valid(rx_valid),
        .rx_msg(rx_msg), .rx_err(rx_err), .Request(Request), .Ack(Ack),
        .interboard_data(interboard_data)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [MSG_W-1:0] exp_tx[$], exp_rx[$];
    logic [MSG_W-1:0] last_rx = '0;
    int exp_txerr = 0, exp_rxerr = 0;
    bit resp_hold = 1'b0;
    int req_rises = 0, r_cnt = 0, r_delay = 0;
    logic prev_req = 1'b0;
    logic [DATA_W-1:0] r_words [NW];
    logic [DATA_W-1:0] last_words [NW];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Far-board responder plus per-cycle comparison against the model
    always @(negedge clk) begin
        logic [NW*DATA_W-1:0] frame;
        logic [MSG_W-1:0] e;
        if (!rst) begin
            tb_ack = 1'b0;
            r_cnt = 0;
            r_delay = 0;
            prev_req = 1'b0;
        end else if (transmit) begin
            if (Request && !prev_req) req_rises++;
            prev_req = Request;
            if (Request && !tb_ack && !resp_hold) begin
                if (r_delay > 0) r_delay--;
                else begin
                    r_words[r_cnt] = interboard_data;
                    tb_ack = 1'b1;
                    r_delay = $urandom_range(0, 3);
                end
            end else if (!Request && tb_ack) begin
                if (r_delay > 0) r_delay--;
                else begin
                    tb_ack = 1'b0;
                    r_delay = $urandom_range(0, 3);
                    r_cnt++;
                    if (r_cnt == NW) begin
                        r_cnt = 0;
                        frame = '0;
                        for (int i = 0; i < NW; i++) begin
                            frame[i*DATA_W +: DATA_W] = r_words[i];
                            last_words[i] = r_words[i];
                        end
                        chk("tx_frame_expected", exp_tx.size() > 0, 1);
                        if (exp_tx.size() > 0) begin
                            e = exp_tx.pop_front();
                            chk("tx_frame", frame, {{(NW*DATA_W-MSG_W){1'b0}}, e});
                        end
                    end
                end
            end
        end
        if (tx_err) begin
            chk("tx_err_expected", exp_txerr > 0, 1);
            if (exp_txerr > 0) begin
                exp_txerr--;
                if (exp_tx.size() > 0) void'(exp_tx.pop_front());
                r_cnt = 0;
            end
        end
        if (rx_valid) begin
            chk("rx_valid_expected", exp_rx.size() > 0, 1);
            if (exp_rx.size() > 0) begin
                e = exp_rx.pop_front();
                chk("rx_msg_on_valid", rx_msg, e);
                last_rx = e;
            end
        end
        if (rx_err) begin
            chk("rx_err_expected", exp_rxerr > 0, 1);
            if (exp_rxerr > 0) exp_rxerr--;
        end
        chk("rx_msg_hold", rx_msg, last_rx);
    end

    task automatic push(input logic [MSG_W-1:0] m, output bit acc);
        tx_valid = 1'b1;
        tx_msg = m;
        acc = tx_ready;
        if (acc) exp_tx.push_back(m);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while ((tx_busy || exp_tx.size() != 0 || tb_ack || r_cnt != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_drain_in_time", n < 3000, 1);
    endtask

    task automatic wait_ack(input logic v);
        int n = 0;
        while (Ack !== v && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ack_in_time", n < 300, 1);
    endtask

    task automatic send_rx(input logic [MSG_W-1:0] m, input int nw);
        logic [NW*DATA_W-1:0] b;
        b = {{(NW*DATA_W-MSG_W){1'b0}}, m};
        if (nw == NW) exp_rx.push_back(m);
        for (int w = 0; w < nw; w++) begin
            tb_data = b[w*DATA_W +: DATA_W];
            repeat ($urandom_range(1, 3)) @(negedge clk);
            tb_req = 1'b1;
            wait_ack(1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            tb_req = 1'b0;
            wait_ack(1'b0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n, lo;
        logic [MSG_W-1:0] m;
        repeat (3) @(negedge clk);
        chk("reset_ack", Ack, 0);
        chk("reset_rx_msg", rx_msg, 0);
        chk("reset_tx_ready", tx_ready, 1);
        chk("reset_tx_busy", tx_busy, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single message loopback with latency and literal word order
        transmit = 1'b1;
        @(negedge clk);
        req_rises = 0;
        push(22'h2A5F3C, acc);
        chk("t1_accept", acc, 1);
        n = 0;
        while (!Request && n < 20) begin @(negedge clk); n++; end
        chk("t1_req_latency", n, 2 + SETUP);
        wait_tx_idle();
        chk("t1_req_pulses", req_rises, NW);
        chk("t1_word0", last_words[0], 6'h3C);
        chk("t1_word1", last_words[1], 6'h3C);
        chk("t1_word2", last_words[2], 6'h25);
        chk("t1_word3", last_words[3], 6'h0A);

        // Fill queue while not owning the bus; the fifth push is refused
        transmit = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            push(MSG_W'($urandom), acc);
            chk("t2_accept", acc, i < DEPTH);
            if (i == DEPTH - 1) chk("t2_full_ready", tx_ready, 0);
        end
        chk("t2_busy_while_rx", tx_busy, 1);
        repeat (5) @(negedge clk);
        chk("t2_queue_kept", tx_busy, 1);
        transmit = 1'b1;
        wait_tx_idle();

        // Push into a full queue in the same cycle as a pop
        transmit = 1'b0;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) push(MSG_W'($urandom), acc);
        m = MSG_W'($urandom);
        transmit = 1'b1;
        tx_valid = 1'b1;
        tx_msg = m;
        chk("t6_full_ready", tx_ready, 0);
        n = 0;
        while (!tx_ready && n < 10) begin @(negedge clk); n++; end
        chk("t6_pop_slot", n, 1);
        exp_tx.push_back(m);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("t6_count_kept", tx_ready, 0);
        wait_tx_idle();

        // Ack stuck low: timeout, gap, then recovery
        resp_hold = 1'b1;
        exp_txerr = 1;
        push(MSG_W'($urandom), acc);
        n = 0;
        while (!Request && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (!tx_err && n < T + 10) begin @(negedge clk); n++; end
        chk("t3_tx_err_latency", n, T);
        resp_hold = 1'b0;
        push(MSG_W'($urandom), acc);
        lo = 0;
        while (!Request && lo < 3 * T) begin @(negedge clk); lo++; end
        chk("t3_req_low_gap", lo >= 2 * T, 1);
        wait_tx_idle();

        // Random traffic in TX direction
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(MSG_W'($urandom), acc);
        end
        wait_tx_idle();

        // Receive direction
        transmit = 1'b0;
        repeat (2) @(negedge clk);
        send_rx(22'h15A0F3, NW);
        repeat (2) @(negedge clk);
        chk("rx_literal", rx_msg, 22'h15A0F3);
        for (int i = 0; i < 6; i++) send_rx(MSG_W'($urandom), NW);
        repeat (3) @(negedge clk);

        // Sender stops after two words
        exp_rxerr = 1;
        send_rx(MSG_W'($urandom), 2);
        n = 0;
        while (!rx_err && n < T + 20) begin @(negedge clk); n++; end
        chk("t4_rx_err_latency", n, T);
        m = MSG_W'($urandom);
        send_rx(m, NW);
        repeat (2) @(negedge clk);
        chk("t4_next_frame", rx_msg, m);

        // Asynchronous reset mid-frame
        transmit = 1'b1;
        @(negedge clk);
        push(MSG_W'($urandom), acc);
        push(MSG_W'($urandom), acc);
        n = 0;
        while (!Request && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #3;
        rst = 1'b0;
        last_rx = '0;
        exp_tx.delete();
        #1;
        chk("t5_request", Request, 0);
        chk("t5_data", interboard_data, 0);
        chk("t5_tx_busy", tx_busy, 0);
        chk("t5_tx_ready", tx_ready, 1);
        chk("t5_rx_msg", rx_msg, 0);
        chk("t5_pulses", {rx_valid, tx_err, rx_err}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5_queue_empty", tx_busy, 0);
        chk("t5_no_request", Request, 0);

        chk("end_tx_queue", exp_tx.size(), 0);
        chk("end_rx_queue", exp_rx.size(), 0);
        chk("end_txerr", exp_txerr, 0);
        chk("end_rxerr", exp_rxerr, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
